// File: rtl/tile_pkg.sv
// Shared constants, state encoding and speed lookup for the falling-tile engine.
// Positions are translated rows (screen row v maps to v+120), 10-bit unsigned.
package tile_pkg;

    localparam logic [9:0] SPAWN_POS  = 10'd120;
    localparam logic [9:0] HIT_LO     = 10'd466;
    localparam logic [9:0] HIT_HI     = 10'd587;
    localparam logic [9:0] RETIRE_POS = 10'd720;

    // Lane bit order shared by chart_lanes, key_pulse and wrong
    localparam int LANE_F    = 0;
    localparam int LANE_G    = 1;
    localparam int LANE_H    = 2;
    localparam int LANE_J    = 3;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Rows advanced per video frame for each difficulty level
    function automatic logic [9:0] speed_for_level(input logic [1:0] lvl);
        logic [9:0] spd;
        case (lvl)
            2'd0:    spd = 10'd2;
            2'd1:    spd = 10'd3;
            2'd2:    spd = 10'd4;
            default: spd = 10'd6;
        endcase
        return spd;
    endfunction

endpackage

// File: rtl/tile_lane.sv
// One piano lane: SLOTS tile positions plus the wrong-flag timer.
// All inputs are single-cycle event strobes; a strobe held high is a new event
// every cycle. There is no backpressure anywhere in this engine.
module tile_lane
    import tile_pkg::*;
#(
    parameter int SLOTS        = 6,
    parameter int WRONG_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               frame_tick,
    input  logic               spawn,
    input  logic               key,
    input  logic [9:0]         speed,
    output logic [SLOTS*10-1:0] pos,
    output logic               wrong,
    output logic               hit,
    output logic               all_empty
);

    logic [9:0]       pos_q [SLOTS];
    logic [9:0]       pos_d [SLOTS];
    logic [4:0]       timer_q;
    logic [4:0]       timer_d;
    logic [SLOTS-1:0] hit_sel;
    logic [SLOTS-1:0] spawn_sel;
    logic             hit_found;
    logic             spawn_found;
    logic             load;
    logic [9:0]       sum;

    // Judge hit on pre-advance positions, pick a spawn slot empty at cycle start,
    // then advance/retire every untouched slot and update the wrong timer.
    // all_empty describes the slots as they will be after this edge.
    always_comb begin
        hit_sel     = '0;
        spawn_sel   = '0;
        hit_found   = 1'b0;
        spawn_found = 1'b0;
        load        = 1'b0;
        sum         = '0;
        hit         = 1'b0;
        timer_d     = timer_q;
        all_empty   = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
            pos_d[s] = pos_q[s];
        end

        for (int s = 0; s < SLOTS; s++) begin
            if (!hit_found && pos_q[s] >= HIT_LO && pos_q[s] <= HIT_HI) begin
                hit_sel[s] = 1'b1;
                hit_found  = 1'b1;
            end
            if (!spawn_found && pos_q[s] == '0) begin
                spawn_sel[s] = 1'b1;
                spawn_found  = 1'b1;
            end
        end

        if (clear) begin
            for (int s = 0; s < SLOTS; s++) begin
                pos_d[s] = '0;
            end
            timer_d = '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (key && hit_sel[s]) begin
                    pos_d[s] = '0;
                end else if (spawn && spawn_sel[s]) begin
                    pos_d[s] = SPAWN_POS;
                end else if (frame_tick && pos_q[s] != '0) begin
                    sum = pos_q[s] + speed;
                    if (sum >= RETIRE_POS) begin
                        pos_d[s] = '0;
                        load     = 1'b1;
                    end else begin
                        pos_d[s] = sum;
                    end
                end
            end
            hit = key && hit_found;
            if (key && !hit_found) begin
                load = 1'b1;
            end
            if (spawn && !spawn_found) begin
                load = 1'b1;
            end
            if (load) begin
                timer_d = 5'(WRONG_FRAMES);
            end else if (frame_tick && timer_q != '0) begin
                timer_d = timer_q - 5'd1;
            end
        end

        for (int s = 0; s < SLOTS; s++) begin
            if (pos_d[s] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    // Register slot positions and the wrong timer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SLOTS; s++) begin
                pos_q[s] <= '0;
            end
            timer_q <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                pos_q[s] <= pos_d[s];
            end
            timer_q <= timer_d;
        end
    end

    // Flatten slot positions for the top level
    always_comb begin
        pos = '0;
        for (int s = 0; s < SLOTS; s++) begin
            pos[s*10 +: 10] = pos_q[s];
        end
    end

    assign wrong = (timer_q != '0);

endmodule

// File: rtl/tile_lane_engine.sv
// Game controller for four falling-tile lanes: FSM, beat counter, score and
// output flattening. A start pulse restarts the game and swallows every other
// event in the same cycle.
module tile_lane_engine
    import tile_pkg::*;
#(
    parameter int SLOTS        = 6,
    parameter int BEATS        = 100,
    parameter int WRONG_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             level,
    input  logic                   frame_tick,
    input  logic                   beat_tick,
    input  logic [3:0]             chart_lanes,
    input  logic [3:0]             key_pulse,
    output logic [4*SLOTS*10-1:0]  lane_pos,
    output logic [3:0]             wrong,
    output logic [6:0]             beat_cnt,
    output logic [9:0]             score,
    output logic                   game_over,
    output state_e                 state_dbg
);

    state_e     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [6:0] beat_cnt_q, beat_cnt_d;
    logic [9:0] score_q, score_d;
    logic       game_over_q, game_over_d;

    logic       live;
    logic       beat_room;
    logic [3:0] spawn_vec;
    logic [3:0] key_vec;
    logic       frame_en;
    logic [3:0] hit_vec;
    logic [3:0] empty_vec;
    logic [9:0] speed;
    logic [2:0] n_hits;
    logic [10:0] score_sum;

    assign live      = (state_q == ST_PLAY) && !start;
    assign beat_room = (beat_cnt_q < 7'(BEATS));
    assign spawn_vec = {4{live && beat_tick && beat_room}} & chart_lanes;
    assign key_vec   = {4{live}} & key_pulse;
    assign frame_en  = live && frame_tick;
    assign speed     = speed_for_level(level_q);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        tile_lane #(
            .SLOTS        (SLOTS),
            .WRONG_FRAMES (WRONG_FRAMES)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clear      (start),
            .frame_tick (frame_en),
            .spawn      (spawn_vec[l]),
            .key        (key_vec[l]),
            .speed      (speed),
            .pos        (lane_pos[l*SLOTS*10 +: SLOTS*10]),
            .wrong      (wrong[l]),
            .hit        (hit_vec[l]),
            .all_empty  (empty_vec[l])
        );
    end

    // Next game state, beat count and saturating score
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        beat_cnt_d = beat_cnt_q;
        score_d    = score_q;
        n_hits     = 3'(hit_vec[0]) + 3'(hit_vec[1]) + 3'(hit_vec[2]) + 3'(hit_vec[3]);
        score_sum  = 11'(score_q) + 11'(n_hits);
        if (start) begin
            state_d    = ST_PLAY;
            level_d    = level;
            beat_cnt_d = '0;
            score_d    = '0;
        end else if (state_q == ST_PLAY) begin
            if (beat_tick && beat_room) begin
                beat_cnt_d = beat_cnt_q + 7'd1;
            end
            score_d = (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
            if (beat_cnt_d == 7'(BEATS) && (&empty_vec)) begin
                state_d = ST_DONE;
            end
        end
        game_over_d = (state_d == ST_DONE);
    end

    // Game FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            beat_cnt_q  <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            beat_cnt_q  <= beat_cnt_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign score     = score_q;
    assign game_over = game_over_q;
    assign state_dbg = state_q;

endmodule
